// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module      : mem_access_sequencer
// Description : Routes one MEM-stage access to dmem, peripheral or multiplier,
//               stalls until the selected target is valid, bounds it by timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_access_sequencer #(
    parameter int PERIPH_BASE = 512,
    parameter int TIMEOUT     = 16,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    input  logic              kill_i,
    input  logic [5:0]        opcode_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic              dmem_valid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              periph_valid_i,
    input  logic [DATA_W-1:0] periph_rdata_i,
    input  logic              mul_valid_i,
    input  logic [DATA_W-1:0] mul_rdata_i,
    output logic              dmem_ce_o,
    output logic              periph_ce_o,
    output logic              mul_ce_o,
    output logic              mul_start_o,
    output logic              hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    localparam int                CNT_W         = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] C_PERIPH_BASE = DATA_W'(PERIPH_BASE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_DMEM   = 2'd1,
        SEL_PERIPH = 2'd2,
        SEL_MUL    = 2'd3
    } sel_t;

    state_t             state_q, state_d;
    sel_t               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    sel_t               w_tgt;
    sel_t               w_ce_sel;
    logic               w_main;
    logic               w_mul;
    logic               w_accept;
    logic               w_in_wait;
    logic               w_sel_valid;
    logic [DATA_W-1:0]  w_sel_rdata;
    logic               w_timeout;
    logic               w_unused_opcode;

    // Low opcode bits carry no routing information.
    assign w_unused_opcode = ^opcode_i[1:0];

    assign w_main = (opcode_i[5:3] == 3'b100) || (opcode_i[5:3] == 3'b101);
    assign w_mul  = (opcode_i[5:2] == 4'b1111);

    always_comb begin
        w_tgt = SEL_NONE;
        if (w_mul) begin
            w_tgt = SEL_MUL;
        end else if (w_main) begin
            w_tgt = (addr_i >= C_PERIPH_BASE) ? SEL_PERIPH : SEL_DMEM;
        end
    end

    // Only the latched target's valid/data matter; other targets are ignored.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rdata = '0;
        case (sel_q)
            SEL_DMEM: begin
                w_sel_valid = dmem_valid_i;
                w_sel_rdata = dmem_rdata_i;
            end
            SEL_PERIPH: begin
                w_sel_valid = periph_valid_i;
                w_sel_rdata = periph_rdata_i;
            end
            SEL_MUL: begin
                w_sel_valid = mul_valid_i;
                w_sel_rdata = mul_rdata_i;
            end
            default: begin
                w_sel_valid = 1'b0;
                w_sel_rdata = '0;
            end
        endcase
    end

    assign w_in_wait = (state_q == ST_WAIT);
    assign w_accept  = (state_q == ST_IDLE) && req_valid_i && !kill_i && (w_tgt != SEL_NONE);
    assign w_timeout = w_in_wait && !w_sel_valid && (cnt_q == C_CNT_LAST);

    assign w_ce_sel = w_accept ? w_tgt : (w_in_wait ? sel_q : SEL_NONE);

    assign dmem_ce_o   = (w_ce_sel == SEL_DMEM);
    assign periph_ce_o = (w_ce_sel == SEL_PERIPH);
    assign mul_ce_o    = (w_ce_sel == SEL_MUL);
    assign mul_start_o = w_accept && (w_tgt == SEL_MUL);
    assign hold_o      = w_accept || (w_in_wait && !w_sel_valid && !w_timeout);

    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = w_in_wait;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_accept) begin
                    state_d = ST_WAIT;
                    sel_d   = w_tgt;
                end
            end
            ST_WAIT: begin
                // Valid takes priority over a timeout landing in the same cycle.
                if (w_sel_valid) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_NONE;
                    cnt_d   = '0;
                    rdata_d = w_sel_rdata;
                    done_d  = 1'b1;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_NONE;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// Module      : tb_mem_access_sequencer
// Description : Directed and random stimulus against a transaction-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

    localparam int DW = 32;
    localparam int TO = 16;
    localparam int PB = 512;

    logic          clk;
    logic          reset;
    logic          req_valid_i;
    logic          kill_i;
    logic [5:0]    opcode_i;
    logic [DW-1:0] addr_i;
    logic          dmem_valid_i;
    logic [DW-1:0] dmem_rdata_i;
    logic          periph_valid_i;
    logic [DW-1:0] periph_rdata_i;
    logic          mul_valid_i;
    logic [DW-1:0] mul_rdata_i;
    logic          dmem_ce_o;
    logic          periph_ce_o;
    logic          mul_ce_o;
    logic          mul_start_o;
    logic          hold_o;
    logic          done_o;
    logic          err_o;
    logic [DW-1:0] rdata_o;
    logic          busy_o;

    mem_access_sequencer #(
        .PERIPH_BASE (PB),
        .TIMEOUT     (TO),
        .DATA_W      (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .kill_i         (kill_i),
        .opcode_i       (opcode_i),
        .addr_i         (addr_i),
        .dmem_valid_i   (dmem_valid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .periph_valid_i (periph_valid_i),
        .periph_rdata_i (periph_rdata_i),
        .mul_valid_i    (mul_valid_i),
        .mul_rdata_i    (mul_rdata_i),
        .dmem_ce_o      (dmem_ce_o),
        .periph_ce_o    (periph_ce_o),
        .mul_ce_o       (mul_ce_o),
        .mul_start_o    (mul_start_o),
        .hold_o         (hold_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .rdata_o        (rdata_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: an outstanding access, its target and age.
    bit          m_busy  = 1'b0;
    int          m_tgt   = 0;
    int          m_age   = 0;
    bit          m_done  = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_rdata = '0;

    int cnt_dce, cnt_pce, cnt_mce, cnt_start, cnt_hold, cnt_done, cnt_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 none, 1 dmem, 2 periph, 3 multiplier
    function automatic int tgt_of(input logic [5:0] op, input logic [31:0] a);
        if (op[5:2] == 4'hF) return 3;
        if (op[5:4] == 2'b10) return (a >= PB) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit valid_of(input int t);
        case (t)
            1: return dmem_valid_i;
            2: return periph_valid_i;
            3: return mul_valid_i;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int t);
        case (t)
            1: return dmem_rdata_i;
            2: return periph_rdata_i;
            3: return mul_rdata_i;
            default: return 32'h0;
        endcase
    endfunction

    task automatic clr_counts();
        cnt_dce = 0; cnt_pce = 0; cnt_mce = 0; cnt_start = 0;
        cnt_hold = 0; cnt_done = 0; cnt_err = 0;
    endtask

    // One clock cycle: compare at mid-cycle, then advance the model across the edge.
    task automatic step();
        int  t;
        bit  acc, sv, tmo;
        int  ce_t;
        logic [7:0] exp_v, act_v;
        #4;
        t    = tgt_of(opcode_i, addr_i);
        acc  = !m_busy && req_valid_i && !kill_i && (t != 0);
        sv   = m_busy && valid_of(m_tgt);
        tmo  = m_busy && !sv && (m_age == TO - 1);
        ce_t = acc ? t : (m_busy ? m_tgt : 0);
        exp_v = {ce_t == 1, ce_t == 2, ce_t == 3, acc && (t == 3),
                 acc || (m_busy && !sv && !tmo), m_done, m_err, m_busy};
        act_v = {dmem_ce_o, periph_ce_o, mul_ce_o, mul_start_o,
                 hold_o, done_o, err_o, busy_o};
        chk("cycle_ctrl{dce,pce,mce,start,hold,done,err,busy}", 64'(act_v), 64'(exp_v));
        chk("cycle_rdata", 64'(rdata_o), 64'(m_rdata));
        cnt_dce   += int'(dmem_ce_o);
        cnt_pce   += int'(periph_ce_o);
        cnt_mce   += int'(mul_ce_o);
        cnt_start += int'(mul_start_o);
        cnt_hold  += int'(hold_o);
        cnt_done  += int'(done_o);
        cnt_err   += int'(err_o);
        if (reset) begin
            m_busy = 0; m_tgt = 0; m_age = 0; m_done = 0; m_err = 0; m_rdata = '0;
        end else begin
            m_done = sv;
            m_err  = tmo;
            if (sv)  m_rdata = data_of(m_tgt);
            if (tmo) m_rdata = '0;
            if (acc) begin
                m_busy = 1; m_tgt = t; m_age = 0;
            end else if (sv || tmo) begin
                m_busy = 0; m_tgt = 0; m_age = 0;
            end else if (m_busy) begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a);
        req_valid_i = 1'b1; opcode_i = op; addr_i = a;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic pulse_valid(input int which, input logic [31:0] d);
        case (which)
            1: begin dmem_valid_i   = 1'b1; dmem_rdata_i   = d; end
            2: begin periph_valid_i = 1'b1; periph_rdata_i = d; end
            default: begin mul_valid_i = 1'b1; mul_rdata_i = d; end
        endcase
        step();
        dmem_valid_i = 1'b0; periph_valid_i = 1'b0; mul_valid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid_i = 0; kill_i = 0; opcode_i = '0; addr_i = '0;
        dmem_valid_i = 0; periph_valid_i = 0; mul_valid_i = 0;
        dmem_rdata_i = '0; periph_rdata_i = '0; mul_rdata_i = '0;
        clr_counts();
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done_err", 64'({done_o, err_o}), 64'd0);
        chk("reset_rdata", 64'(rdata_o), 64'd0);

        // Load to dmem, valid two cycles after accept.
        clr_counts();
        issue(6'b100000, 32'h100); idle(1); pulse_valid(1, 32'hDEADBEEF); idle(1);
        chk("load_dmem_ce_cycles", 64'(cnt_dce), 64'd3);
        chk("load_hold_cycles", 64'(cnt_hold), 64'd2);
        chk("load_done_pulses", 64'(cnt_done), 64'd1);
        chk("load_rdata", 64'(rdata_o), 64'hDEADBEEF);

        // Address boundary on either side of the peripheral base.
        clr_counts();
        issue(6'b100010, 32'd511); pulse_valid(1, 32'h11); idle(1);
        chk("addr511_dmem_ce", 64'(cnt_dce), 64'd2);
        chk("addr511_periph_ce", 64'(cnt_pce), 64'd0);
        clr_counts();
        issue(6'b100010, 32'd512); pulse_valid(2, 32'h22); idle(1);
        chk("addr512_periph_ce", 64'(cnt_pce), 64'd2);
        chk("addr512_dmem_ce", 64'(cnt_dce), 64'd0);

        // Store to peripheral.
        clr_counts();
        issue(6'b101000, 32'h204); idle(1); pulse_valid(2, 32'hCAFE0001); idle(1);
        chk("store_periph_ce", 64'(cnt_pce), 64'd3);
        chk("store_done", 64'(cnt_done), 64'd1);
        chk("store_rdata", 64'(rdata_o), 64'hCAFE0001);

        // Multiply, result five cycles after accept.
        clr_counts();
        issue(6'b111100, 32'h0); idle(4); pulse_valid(3, 32'h30); idle(1);
        chk("mul_start_cycles", 64'(cnt_start), 64'd1);
        chk("mul_ce_cycles", 64'(cnt_mce), 64'd6);
        chk("mul_done", 64'(cnt_done), 64'd1);
        chk("mul_rdata", 64'(rdata_o), 64'h30);

        // Dead target: timeout.
        clr_counts();
        issue(6'b100000, 32'h10); idle(TO); idle(1);
        chk("timeout_hold_cycles", 64'(cnt_hold), 64'd16);
        chk("timeout_err_pulses", 64'(cnt_err), 64'd1);
        chk("timeout_done_pulses", 64'(cnt_done), 64'd0);
        chk("timeout_rdata", 64'(rdata_o), 64'd0);
        chk("timeout_busy", 64'(busy_o), 64'd0);
        clr_counts();
        issue(6'b100000, 32'h20);
        chk("reaccept_dmem_ce", 64'(cnt_dce), 64'd1);
        chk("reaccept_hold", 64'(cnt_hold), 64'd1);
        pulse_valid(1, 32'h77); idle(1);

        // Spurious valid from a non-selected target.
        clr_counts();
        issue(6'b100000, 32'h40); pulse_valid(2, 32'hBAD);
        chk("spurious_hold", 64'(cnt_hold), 64'd2);
        chk("spurious_no_done", 64'(busy_o), 64'd1);
        pulse_valid(1, 32'h55); idle(1);
        chk("spurious_rdata", 64'(rdata_o), 64'h55);

        // Valid on the final wait cycle beats the timeout.
        clr_counts();
        issue(6'b100000, 32'h44); idle(TO - 1); pulse_valid(1, 32'h12345678); idle(1);
        chk("race_done", 64'(cnt_done), 64'd1);
        chk("race_err", 64'(cnt_err), 64'd0);
        chk("race_rdata", 64'(rdata_o), 64'h12345678);

        // Reset in the third wait cycle.
        issue(6'b100000, 32'h48); idle(2);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midreset_ctrl", 64'({busy_o, hold_o, dmem_ce_o, done_o, err_o}), 64'd0);
        chk("midreset_rdata", 64'(rdata_o), 64'd0);
        idle(1);

        // Kill blocks acceptance.
        clr_counts();
        kill_i = 1'b1; issue(6'b100000, 32'h8); kill_i = 1'b0; idle(2);
        chk("kill_no_ce", 64'(cnt_dce), 64'd0);
        chk("kill_no_hold", 64'(cnt_hold), 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            req_valid_i = ($urandom_range(0, 2) != 0);
            kill_i      = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: opcode_i = {3'b100, 3'($urandom)};
                1: opcode_i = {3'b101, 3'($urandom)};
                2: opcode_i = {4'b1111, 2'($urandom)};
                default: opcode_i = 6'($urandom);
            endcase
            addr_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(PB - 4, PB + 3)) : $urandom;
            dmem_valid_i   = ($urandom_range(0, 5) == 0);
            periph_valid_i = ($urandom_range(0, 5) == 0);
            mul_valid_i    = ($urandom_range(0, 5) == 0);
            dmem_rdata_i   = $urandom;
            periph_rdata_i = $urandom;
            mul_rdata_i    = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
